// File: rtl/cellrv32_cpu_regfile_mp_if.sv
// Register file bus: write ports, read ports, scoreboard and status.
// master = CPU back-end side, slave = register file.
interface cellrv32_cpu_regfile_mp_if #(
   parameter int XLEN       = 32,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RPORTS = 4
);
   logic                         ready_o;
   logic                         wr0_en_i;
   logic [4:0]                   wr0_addr_i;
   logic [XLEN-1:0]              wr0_data_i;
   logic                         wr1_en_i;
   logic [4:0]                   wr1_addr_i;
   logic [XLEN-1:0]              wr1_data_i;
   logic [5*NUM_RPORTS-1:0]      rd_addr_i;
   logic [XLEN*NUM_RPORTS-1:0]   rd_data_o;
   logic [NUM_RPORTS-1:0]        rd_busy_o;
   logic                         sb_set_i;
   logic [4:0]                   sb_addr_i;
   logic [NUM_REGS-1:0]          busy_o;

   modport master (
      input  ready_o, rd_data_o, rd_busy_o, busy_o,
      output wr0_en_i, wr0_addr_i, wr0_data_i,
      output wr1_en_i, wr1_addr_i, wr1_data_i,
      output rd_addr_i, sb_set_i, sb_addr_i
   );

   modport slave (
      output ready_o, rd_data_o, rd_busy_o, busy_o,
      input  wr0_en_i, wr0_addr_i, wr0_data_i,
      input  wr1_en_i, wr1_addr_i, wr1_data_i,
      input  rd_addr_i, sb_set_i, sb_addr_i
   );
endinterface

// File: rtl/cellrv32_cpu_regfile_mp.sv
// Multi-port GPR file: NUM_RPORTS registered reads, 2 write ports
// (port 1 wins), optional write->read bypass, busy scoreboard and
// a self-clearing init sequencer.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport).
module cellrv32_cpu_regfile_mp #(
   parameter int XLEN       = 32,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RPORTS = 4,
   parameter int BYPASS_EN  = 1
) (
   input logic                    clk_i,
   input logic                    rst_i,
   cellrv32_cpu_regfile_mp_if.slave bus
);
   // RV32E decodes only the low 4 address bits
   localparam int AW = (NUM_REGS == 16) ? 4 : 5;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                      r_state, w_state_nxt;
   logic [AW-1:0]               r_cnt, w_cnt_nxt;
   logic [XLEN-1:0]             r_mem [NUM_REGS];
   logic [NUM_REGS-1:0]         r_busy, w_busy_nxt;
   logic [XLEN*NUM_RPORTS-1:0]  r_rd_data, w_rd_data;
   logic [NUM_RPORTS-1:0]       r_rd_busy, w_rd_busy;

   logic          w_run;
   logic [AW-1:0] w_wa0, w_wa1, w_sa;
   logic          w_we0, w_we1, w_sb_set;

   assign w_run    = (r_state == S_RUN);
   assign w_wa0    = bus.wr0_addr_i[AW-1:0];
   assign w_wa1    = bus.wr1_addr_i[AW-1:0];
   assign w_sa     = bus.sb_addr_i[AW-1:0];
   // x0 is never written nor marked busy
   assign w_we0    = w_run & bus.wr0_en_i & (w_wa0 != '0);
   assign w_we1    = w_run & bus.wr1_en_i & (w_wa1 != '0);
   assign w_sb_set = w_run & bus.sb_set_i & (w_sa != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_INIT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == AW'(NUM_REGS - 1))
               w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // set applied last: a new producer supersedes a retiring write
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_we0)    w_busy_nxt[w_wa0] = 1'b0;
      if (w_we1)    w_busy_nxt[w_wa1] = 1'b0;
      if (w_sb_set) w_busy_nxt[w_sa]  = 1'b1;
   end

   always_comb begin
      logic [AW-1:0]   v_ra;
      logic [XLEN-1:0] v_rd;
      w_rd_data = '0;
      w_rd_busy = '0;
      v_ra      = '0;
      v_rd      = '0;
      for (int p = 0; p < NUM_RPORTS; p++) begin
         v_ra = bus.rd_addr_i[5*p +: AW];
         v_rd = (v_ra == '0) ? '0 : r_mem[v_ra];
         if (BYPASS_EN != 0) begin
            if (w_we0 && (w_wa0 == v_ra)) v_rd = bus.wr0_data_i;
            if (w_we1 && (w_wa1 == v_ra)) v_rd = bus.wr1_data_i;
         end
         if (!w_run) v_rd = '0;
         w_rd_data[XLEN*p +: XLEN] = v_rd;
         w_rd_busy[p] = w_run & w_busy_nxt[v_ra];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_INIT;
         r_cnt     <= '0;
         r_busy    <= '0;
         r_rd_data <= '0;
         r_rd_busy <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_busy    <= w_busy_nxt;
         r_rd_data <= w_rd_data;
         r_rd_busy <= w_rd_busy;
      end
   end

   // port 1 assigned last so it wins on an address collision
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (!w_run) begin
            r_mem[r_cnt] <= '0;
         end else begin
            if (w_we0) r_mem[w_wa0] <= bus.wr0_data_i;
            if (w_we1) r_mem[w_wa1] <= bus.wr1_data_i;
         end
      end
   end

   assign bus.ready_o   = w_run;
   assign bus.rd_data_o = r_rd_data;
   assign bus.rd_busy_o = r_rd_busy;
   assign bus.busy_o    = r_busy;
endmodule
